// File: rtl/cpu_session_ctrl.sv
// cpu_session_ctrl: run-control sequencer for the pipelined RISC-V cpu.
// Preloads instruction/data memory from a word stream, runs the core for a
// programmed number of cycles, then streams back a block of data memory.
module cpu_session_ctrl #(
   parameter int unsigned CYC_W      = 32,
   parameter int unsigned IMEM_WORDS = 512,
   parameter int unsigned DMEM_WORDS = 1024
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [9:0]       imem_len,
   input  logic [10:0]      dmem_len,
   input  logic [CYC_W-1:0] run_cycles,
   input  logic [10:0]      dump_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_data,
   output logic [63:0]      imem_addr,
   output logic             imem_wen,
   output logic             imem_ren,
   output logic [31:0]      imem_wdata,
   output logic [63:0]      dmem_addr,
   output logic             dmem_wen,
   output logic             dmem_ren,
   output logic [63:0]      dmem_wdata,
   input  logic [63:0]      dmem_rdata,
   output logic             cpu_enable,
   output logic             busy,
   output logic             done,
   output logic [CYC_W-1:0] cycle_count
);

   localparam int unsigned LEN_W  = 11;
   localparam int unsigned ADDR_W = 64;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD_I   = 3'd1,
      S_LOAD_D   = 3'd2,
      S_RUN      = 3'd3,
      S_DUMP_REQ = 3'd4,
      S_DUMP_OUT = 3'd5,
      S_DONE     = 3'd6
   } state_t;

   // First phase with work to do, starting after 'stage'
   // (0: from start, 1: after imem load, 2: after dmem load, 3: after run).
   function automatic state_t seq_next(input logic [1:0] stage,
                                       input logic       i_nz,
                                       input logic       d_nz,
                                       input logic       r_nz,
                                       input logic       u_nz);
      state_t s;
      s = S_DONE;
      if (u_nz) s = S_DUMP_REQ;
      if (r_nz && (stage <= 2'd2)) s = S_RUN;
      if (d_nz && (stage <= 2'd1)) s = S_LOAD_D;
      if (i_nz && (stage == 2'd0)) s = S_LOAD_I;
      return s;
   endfunction

   state_t             state_q;
   state_t             state_d;
   logic [LEN_W-1:0]   idx_q;
   logic [LEN_W-1:0]   ilen_q;
   logic [LEN_W-1:0]   dlen_q;
   logic [LEN_W-1:0]   ulen_q;
   logic [CYC_W-1:0]   run_q;
   logic [CYC_W-1:0]   cycle_q;
   logic [63:0]        out_hold_q;
   logic               dump_first_q;

   logic [LEN_W-1:0]   ilen_clamp;
   logic [LEN_W-1:0]   dlen_clamp;
   logic [LEN_W-1:0]   ulen_clamp;
   logic [LEN_W-1:0]   idx_inc;
   logic               i_last;
   logic               d_last;
   logic               u_last;
   logic               run_last;

   // Length clamping to memory depth, applied when the session is latched
   assign ilen_clamp = (LEN_W'(imem_len) > LEN_W'(IMEM_WORDS)) ? LEN_W'(IMEM_WORDS) : LEN_W'(imem_len);
   assign dlen_clamp = (LEN_W'(dmem_len) > LEN_W'(DMEM_WORDS)) ? LEN_W'(DMEM_WORDS) : LEN_W'(dmem_len);
   assign ulen_clamp = (LEN_W'(dump_len) > LEN_W'(DMEM_WORDS)) ? LEN_W'(DMEM_WORDS) : LEN_W'(dump_len);

   // Terminal compares; the 11-bit index reaches 1024 without wrapping
   assign idx_inc  = idx_q + LEN_W'(1);
   assign i_last   = (idx_inc == ilen_q);
   assign d_last   = (idx_inc == dlen_q);
   assign u_last   = (idx_inc == ulen_q);
   assign run_last = ((cycle_q + CYC_W'(1)) == run_q);

   assign cycle_count = cycle_q;

   // State register
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort overrides every transition
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_d = seq_next(2'd0, ilen_clamp != '0, dlen_clamp != '0,
                                     run_cycles != '0, ulen_clamp != '0);
               end
            end
            S_LOAD_I: begin
               if (in_valid && i_last) begin
                  state_d = seq_next(2'd1, 1'b0, dlen_q != '0, run_q != '0, ulen_q != '0);
               end
            end
            S_LOAD_D: begin
               if (in_valid && d_last) begin
                  state_d = seq_next(2'd2, 1'b0, 1'b0, run_q != '0, ulen_q != '0);
               end
            end
            S_RUN: begin
               if (run_last) begin
                  state_d = seq_next(2'd3, 1'b0, 1'b0, 1'b0, ulen_q != '0);
               end
            end
            S_DUMP_REQ: begin
               state_d = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
               if (out_ready) begin
                  state_d = u_last ? S_DONE : S_DUMP_REQ;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Session datapath: latched lengths, word index, run counter, dump capture
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         idx_q        <= '0;
         ilen_q       <= '0;
         dlen_q       <= '0;
         ulen_q       <= '0;
         run_q        <= '0;
         cycle_q      <= '0;
         out_hold_q   <= '0;
         dump_first_q <= 1'b0;
      end else if (abort) begin
         dump_first_q <= 1'b0;
      end else begin
         dump_first_q <= (state_q == S_DUMP_REQ);
         if (dump_first_q) begin
            out_hold_q <= dmem_rdata;
         end
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  ilen_q  <= ilen_clamp;
                  dlen_q  <= dlen_clamp;
                  ulen_q  <= ulen_clamp;
                  run_q   <= run_cycles;
                  idx_q   <= '0;
                  cycle_q <= '0;
               end
            end
            S_LOAD_I: begin
               if (in_valid) idx_q <= i_last ? '0 : idx_inc;
            end
            S_LOAD_D: begin
               if (in_valid) idx_q <= d_last ? '0 : idx_inc;
            end
            S_RUN: begin
               cycle_q <= cycle_q + CYC_W'(1);
            end
            S_DUMP_OUT: begin
               if (out_ready) idx_q <= u_last ? '0 : idx_inc;
            end
            default: begin
            end
         endcase
      end
   end

   // Output decode from state, index and stream inputs; abort kills strobes
   always_comb begin
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      imem_addr  = '0;
      imem_wen   = 1'b0;
      imem_ren   = 1'b0;
      imem_wdata = '0;
      dmem_addr  = '0;
      dmem_wen   = 1'b0;
      dmem_ren   = 1'b0;
      dmem_wdata = '0;
      cpu_enable = 1'b0;
      busy       = (state_q != S_IDLE) && (state_q != S_DONE);
      done       = (state_q == S_DONE);
      // First DUMP_OUT cycle forwards the SRAM read data; later cycles hold it
      out_data   = dump_first_q ? dmem_rdata : out_hold_q;
      case (state_q)
         S_LOAD_I: begin
            in_ready   = !abort;
            imem_addr  = ADDR_W'(idx_q) << 2;
            imem_wen   = in_valid && !abort;
            imem_wdata = in_data[31:0];
         end
         S_LOAD_D: begin
            in_ready   = !abort;
            dmem_addr  = ADDR_W'(idx_q) << 3;
            dmem_wen   = in_valid && !abort;
            dmem_wdata = in_data;
         end
         S_RUN: begin
            cpu_enable = !abort;
         end
         S_DUMP_REQ: begin
            dmem_addr = ADDR_W'(idx_q) << 3;
            dmem_ren  = !abort;
         end
         S_DUMP_OUT: begin
            out_valid = !abort;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_cpu_session_ctrl.sv
// Directed bench for cpu_session_ctrl with a synchronous-read data SRAM model.
module tb_cpu_session_ctrl;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [9:0]  imem_len = '0;
   logic [10:0] dmem_len = '0;
   logic [31:0] run_cycles = '0;
   logic [10:0] dump_len = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_data;
   logic [63:0] imem_addr;
   logic        imem_wen;
   logic        imem_ren;
   logic [31:0] imem_wdata;
   logic [63:0] dmem_addr;
   logic        dmem_wen;
   logic        dmem_ren;
   logic [63:0] dmem_wdata;
   logic [63:0] dmem_rdata = '0;
   logic        cpu_enable;
   logic        busy;
   logic        done;
   logic [31:0] cycle_count;

   int total = 0;
   int bad = 0;

   logic [63:0] stream [0:2047];
   logic [63:0] dmem_m [0:1023];
   logic [63:0] im_a[$];
   logic [31:0] im_d[$];
   logic [63:0] dm_a[$];
   logic [63:0] dm_d[$];
   logic [63:0] dump_q[$];
   int en_cnt, en_viol, rd_cnt;
   int stall_seen, stall_bad;
   int cyc;
   bit tmo;

   logic        dw_s = 1'b0, dr_s = 1'b0;
   logic [63:0] da_s = '0, dwd_s = '0;

   cpu_session_ctrl dut (
      .clk(clk), .arst_n(arst_n), .start(start), .abort(abort),
      .imem_len(imem_len), .dmem_len(dmem_len), .run_cycles(run_cycles), .dump_len(dump_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_ren(imem_ren), .imem_wdata(imem_wdata),
      .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_ren(dmem_ren), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .cpu_enable(cpu_enable), .busy(busy), .done(done),
      .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   // Transaction monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (imem_wen) begin im_a.push_back(imem_addr); im_d.push_back(imem_wdata); end
      if (dmem_wen) begin dm_a.push_back(dmem_addr); dm_d.push_back(dmem_wdata); end
      if (dmem_ren) rd_cnt++;
      if (cpu_enable) begin
         en_cnt++;
         if (imem_wen || dmem_wen || dmem_ren) en_viol++;
      end
      if (imem_ren) en_viol++;
      if (out_valid && out_ready) dump_q.push_back(out_data);
      dw_s  <= dmem_wen;
      dr_s  <= dmem_ren;
      da_s  <= dmem_addr;
      dwd_s <= dmem_wdata;
   end

   // Data SRAM model: write and 1-cycle read on the clock edge
   always @(posedge clk) begin
      if (dw_s) dmem_m[da_s[12:3]] <= dwd_s;
      if (dr_s) dmem_rdata <= dmem_m[da_s[12:3]];
   end

   task automatic clear_logs();
      im_a.delete(); im_d.delete(); dm_a.delete(); dm_d.delete(); dump_q.delete();
      en_cnt = 0; en_viol = 0; rd_cnt = 0; stall_seen = 0; stall_bad = 0;
   endtask

   // Drives one full session; returns edges after the start edge until done
   task automatic run_session(input logic [9:0] il, input logic [10:0] dl,
                              input logic [31:0] rc, input logic [10:0] ul,
                              input bit alt_valid, input int stall_n, input int pulse_at);
      int k;
      int stall_left;
      logic [63:0] ref_data;
      @(posedge clk); #1;
      clear_logs();
      imem_len = il; dmem_len = dl; run_cycles = rc; dump_len = ul;
      start = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
      stall_left = stall_n; ref_data = '0;
      @(posedge clk); #1;
      start = 1'b0; cyc = 0; k = 0; tmo = 1'b0;
      while (done !== 1'b1) begin
         if (cyc >= 5000) begin tmo = 1'b1; break; end
         in_valid = alt_valid ? (cyc % 2 == 1) : 1'b1;
         in_data = stream[k];
         start = (pulse_at > 0) && (cyc == pulse_at);
         if (start) begin run_cycles = 32'd50; imem_len = 10'd5; end
         out_ready = !(out_valid && stall_left > 0);
         @(negedge clk); #1;
         if (in_valid && in_ready) k++;
         if (!out_ready) begin
            if (!out_valid) stall_bad++;
            if (stall_seen == 0) ref_data = out_data;
            else if (out_data !== ref_data) stall_bad++;
            stall_seen++;
            stall_left--;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", done); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
      total++; if (cpu_enable !== 1'b0) begin bad++; $display("FAIL reset_cpu_enable: got %0b want 0", cpu_enable); end
      total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL reset_cycle_count: got %0d want 0", cycle_count); end
      total++; if (out_data !== 64'd0) begin bad++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
      total++; if ({imem_wen, imem_ren, dmem_wen, dmem_ren} !== 4'b0) begin bad++;
         $display("FAIL reset_strobes: got %b want 0000", {imem_wen, imem_ren, dmem_wen, dmem_ren}); end
      @(negedge clk);
      arst_n = 1'b1;
   endtask

   task automatic test_load_run_dump();
      run_session(10'd4, 11'd2, 32'd10, 11'd2, 1'b0, 0, 0);
      total++; if (tmo) begin bad++; $display("FAIL lrd_timeout: got timeout want done"); end
      total++; if (cyc !== 20) begin bad++; $display("FAIL lrd_latency: got %0d want 20", cyc); end
      total++; if (im_a.size() !== 4) begin bad++; $display("FAIL lrd_imem_count: got %0d want 4", im_a.size()); end
      for (int i = 0; i < 4; i++) begin
         total++; if (im_a[i] !== 64'(i * 4) || im_d[i] !== stream[i][31:0]) begin bad++;
            $display("FAIL lrd_imem_%0d: got %0h/%0h want %0h/%0h", i, im_a[i], im_d[i], i * 4, stream[i][31:0]); end
      end
      total++; if (dm_a.size() !== 2) begin bad++; $display("FAIL lrd_dmem_count: got %0d want 2", dm_a.size()); end
      for (int j = 0; j < 2; j++) begin
         total++; if (dm_a[j] !== 64'(j * 8) || dm_d[j] !== stream[4 + j]) begin bad++;
            $display("FAIL lrd_dmem_%0d: got %0h/%0h want %0h/%0h", j, dm_a[j], dm_d[j], j * 8, stream[4 + j]); end
      end
      total++; if (en_cnt !== 10) begin bad++; $display("FAIL lrd_enable_cycles: got %0d want 10", en_cnt); end
      total++; if (en_viol !== 0) begin bad++; $display("FAIL lrd_ext_during_run: got %0d want 0", en_viol); end
      total++; if (dump_q.size() !== 2) begin bad++; $display("FAIL lrd_dump_count: got %0d want 2", dump_q.size()); end
      for (int j = 0; j < 2; j++) begin
         total++; if (dump_q[j] !== stream[4 + j]) begin bad++;
            $display("FAIL lrd_dump_%0d: got %0h want %0h", j, dump_q[j], stream[4 + j]); end
      end
      total++; if (cycle_count !== 32'd10) begin bad++; $display("FAIL lrd_cycle_count: got %0d want 10", cycle_count); end
      total++; if (busy !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL lrd_final: got busy=%0b done=%0b want 0/1", busy, done); end
   endtask

   task automatic test_backpressure();
      run_session(10'd3, 11'd2, 32'd1, 11'd2, 1'b1, 5, 0);
      total++; if (tmo) begin bad++; $display("FAIL bp_timeout: got timeout want done"); end
      total++; if (im_a.size() !== 3) begin bad++; $display("FAIL bp_imem_count: got %0d want 3", im_a.size()); end
      for (int i = 0; i < 3; i++) begin
         total++; if (im_a[i] !== 64'(i * 4) || im_d[i] !== stream[i][31:0]) begin bad++;
            $display("FAIL bp_imem_%0d: got %0h/%0h want %0h/%0h", i, im_a[i], im_d[i], i * 4, stream[i][31:0]); end
      end
      total++; if (dm_a.size() !== 2) begin bad++; $display("FAIL bp_dmem_count: got %0d want 2", dm_a.size()); end
      total++; if (stall_seen !== 5) begin bad++; $display("FAIL bp_stall_cycles: got %0d want 5", stall_seen); end
      total++; if (stall_bad !== 0) begin bad++; $display("FAIL bp_stall_stable: got %0d changes want 0", stall_bad); end
      for (int j = 0; j < 2; j++) begin
         total++; if (dump_q[j] !== stream[3 + j]) begin bad++;
            $display("FAIL bp_dump_%0d: got %0h want %0h", j, dump_q[j], stream[3 + j]); end
      end
      total++; if (rd_cnt !== 2) begin bad++; $display("FAIL bp_read_count: got %0d want 2", rd_cnt); end
   endtask

   task automatic test_zero_lengths();
      run_session(10'd0, 11'd0, 32'd0, 11'd0, 1'b0, 0, 0);
      total++; if (tmo || cyc !== 0) begin bad++; $display("FAIL zero_latency: got %0d tmo=%0b want 0", cyc, tmo); end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done: got %0b want 1", done); end
      total++; if (im_a.size() + dm_a.size() + rd_cnt + en_cnt !== 0) begin bad++;
         $display("FAIL zero_activity: got %0d want 0", im_a.size() + dm_a.size() + rd_cnt + en_cnt); end
   endtask

   task automatic test_abort_load();
      int k;
      clear_logs();
      @(posedge clk); #1;
      imem_len = 10'd4; dmem_len = 11'd4; run_cycles = 32'd5; dump_len = 11'd0;
      start = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; k = 0;
      repeat (5) begin
         in_data = stream[k];
         @(negedge clk); #1;
         if (in_valid && in_ready) k++;
         @(posedge clk); #1;
      end
      total++; if (im_a.size() !== 4 || dm_a.size() !== 1) begin bad++;
         $display("FAIL abort_pre: got imem=%0d dmem=%0d want 4/1", im_a.size(), dm_a.size()); end
      in_data = stream[k];
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      total++; if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin bad++;
         $display("FAIL abort_idle: got busy=%0b done=%0b in_ready=%0b want 0/0/0", busy, done, in_ready); end
      repeat (3) @(posedge clk);
      #1;
      total++; if (dm_a.size() !== 1) begin bad++; $display("FAIL abort_no_dwen: got %0d want 1", dm_a.size()); end
      in_valid = 1'b0;
      run_session(10'd2, 11'd0, 32'd0, 11'd0, 1'b0, 0, 0);
      total++; if (tmo || cyc !== 2) begin bad++; $display("FAIL abort_restart_latency: got %0d want 2", cyc); end
      total++; if (im_a.size() !== 2 || im_a[0] !== 64'd0 || im_a[1] !== 64'd4) begin bad++;
         $display("FAIL abort_restart_addr: got n=%0d a0=%0h want 2/0", im_a.size(), im_a[0]); end
   endtask

   task automatic test_abort_run();
      int guard;
      @(posedge clk); #1;
      imem_len = '0; dmem_len = '0; run_cycles = 32'd100; dump_len = '0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; guard = 0;
      while (cycle_count !== 32'd30 && guard < 200) begin @(posedge clk); #1; guard++; end
      total++; if (guard >= 200) begin bad++; $display("FAIL abrun_timeout: got count %0d want 30", cycle_count); end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      total++; if (cycle_count !== 32'd30) begin bad++; $display("FAIL abrun_count_held: got %0d want 30", cycle_count); end
      total++; if (cpu_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin bad++;
         $display("FAIL abrun_idle: got en=%0b busy=%0b done=%0b want 0/0/0", cpu_enable, busy, done); end
   endtask

   task automatic test_start_ignored();
      run_session(10'd0, 11'd0, 32'd8, 11'd0, 1'b0, 0, 4);
      total++; if (tmo || cyc !== 8) begin bad++; $display("FAIL ign_latency: got %0d want 8", cyc); end
      total++; if (en_cnt !== 8) begin bad++; $display("FAIL ign_enable_cycles: got %0d want 8", en_cnt); end
      total++; if (cycle_count !== 32'd8) begin bad++; $display("FAIL ign_cycle_count: got %0d want 8", cycle_count); end
      total++; if (im_a.size() !== 0) begin bad++; $display("FAIL ign_no_load: got %0d want 0", im_a.size()); end
   endtask

   task automatic test_clamp();
      run_session(10'd1000, 11'd0, 32'd0, 11'd0, 1'b0, 0, 0);
      total++; if (tmo || cyc !== 512) begin bad++; $display("FAIL clamp_i_latency: got %0d want 512", cyc); end
      total++; if (im_a.size() !== 512 || im_a[511] !== 64'd2044) begin bad++;
         $display("FAIL clamp_i_writes: got n=%0d last=%0h want 512/7fc", im_a.size(), im_a[511]); end
      run_session(10'd0, 11'd1500, 32'd0, 11'd0, 1'b0, 0, 0);
      total++; if (dm_a.size() !== 1024 || dm_a[1023] !== 64'd8184) begin bad++;
         $display("FAIL clamp_d_writes: got n=%0d last=%0h want 1024/1ff8", dm_a.size(), dm_a[1023]); end
   endtask

   task automatic test_reset_mid_run();
      int guard;
      @(posedge clk); #1;
      imem_len = '0; dmem_len = '0; run_cycles = 32'd100; dump_len = '0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; guard = 0;
      while (cycle_count !== 32'd40 && guard < 200) begin @(posedge clk); #1; guard++; end
      total++; if (cpu_enable !== 1'b1 || guard >= 200) begin bad++;
         $display("FAIL rst_run_pre: got en=%0b count=%0d want 1/40", cpu_enable, cycle_count); end
      arst_n = 1'b0;
      #1;
      total++; if (cpu_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin bad++;
         $display("FAIL rst_run_ctrl: got en=%0b busy=%0b done=%0b want 0/0/0", cpu_enable, busy, done); end
      total++; if (cycle_count !== 32'd0 || out_data !== 64'd0) begin bad++;
         $display("FAIL rst_run_regs: got count=%0d data=%0h want 0/0", cycle_count, out_data); end
      total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin bad++;
         $display("FAIL rst_run_hs: got in_ready=%0b out_valid=%0b want 0/0", in_ready, out_valid); end
      @(negedge clk);
      arst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) begin
         stream[i] = {32'hCAFE_0000 ^ 32'(i * 7), 32'h1000_0000 + 32'(i)};
      end
      for (int i = 0; i < 1024; i++) dmem_m[i] = '0;
      test_reset();
      test_load_run_dump();
      test_backpressure();
      test_zero_lengths();
      test_abort_load();
      test_abort_run();
      test_start_ignored();
      test_clamp();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
